// File: rtl/instruction_sequencer.sv
// Instruction sequencer: stores a host-loaded program and issues one 16-bit word
// per clock to the cpu, inserting NOPs after operate/burst-read words.
module instruction_sequencer #(
  parameter int unsigned PROGRAM_DEPTH           = 256,
  parameter int unsigned ADDRESS_WIDTH           = 8,
  parameter int unsigned OPERATE_STALL_CYCLES    = 5,
  parameter int unsigned BURST_READ_STALL_CYCLES = 9,
  parameter int unsigned BURST_WRITE_DATA_WORDS  = 5
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     load_clear_in,
  input  logic                     load_enable_in,
  input  logic [15:0]              load_data_in,
  output logic                     load_ready_out,
  input  logic                     start_in,
  output logic [15:0]              current_instruction_out,
  output logic [ADDRESS_WIDTH-1:0] program_counter_out,
  output logic [ADDRESS_WIDTH:0]   program_length_out,
  output logic                     busy_out,
  output logic                     done_out
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned LEN_W   = ADDRESS_WIDTH + 1;
  localparam int unsigned MAX_A   = (OPERATE_STALL_CYCLES > BURST_READ_STALL_CYCLES) ?
                                    OPERATE_STALL_CYCLES : BURST_READ_STALL_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > BURST_WRITE_DATA_WORDS) ? MAX_A : BURST_WRITE_DATA_WORDS;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [WORD_W-1:0] NOP_WORD   = '0;
  localparam logic [WORD_W-1:0] RESET_WORD = 16'h000C;
  localparam logic [LEN_W-1:0]  DEPTH_L    = LEN_W'(PROGRAM_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_OP     = CNT_W'(OPERATE_STALL_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_BR     = CNT_W'(BURST_READ_STALL_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_BW     = CNT_W'(BURST_WRITE_DATA_WORDS);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_pc;
  logic [LEN_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_count;
  logic [WORD_W-1:0] r_out;
  logic              r_busy;
  logic              r_done;
  logic              r_done_pend;
  logic              r_load_ready;
  logic [WORD_W-1:0] r_mem [PROGRAM_DEPTH];

  state_t            w_state_next;
  logic [LEN_W-1:0]  w_pc_next;
  logic [LEN_W-1:0]  w_wp_next;
  logic [LEN_W-1:0]  w_wp_rst;
  logic [LEN_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0]  w_count_next;
  logic [WORD_W-1:0] w_out_next;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_done_next;
  logic              w_done_pend_next;
  logic              w_we;

  assign w_rd_word = r_mem[r_pc[ADDRESS_WIDTH-1:0]];
  assign w_pc_inc  = r_pc + LEN_W'(1);
  // A reset that interrupts a run keeps the loaded program; a reset seen in IDLE clears it.
  assign w_wp_rst  = (r_state == S_IDLE) ? '0 : r_wp;

  // Next-state, next-output and load control.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_wp_next        = r_wp;
    w_count_next     = r_count;
    w_out_next       = NOP_WORD;
    w_done_next      = 1'b0;
    w_done_pend_next = 1'b0;
    w_we             = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_done_next = r_done_pend;
        if (start_in) begin
          w_pc_next = '0;
          if (r_wp == '0) w_done_next  = 1'b1;
          else            w_state_next = S_ISSUE;
        end else if (load_clear_in) begin
          w_wp_next = '0;
        end else if (load_enable_in && (r_wp < DEPTH_L)) begin
          w_we      = 1'b1;
          w_wp_next = r_wp + LEN_W'(1);
        end
      end
      S_ISSUE: begin
        w_out_next = w_rd_word;
        w_pc_next  = w_pc_inc;
        if (w_rd_word[1:0] == 2'b10) begin
          w_state_next = S_STALL;
          w_count_next = CNT_OP;
        end else if (w_rd_word[1:0] == 2'b11) begin
          w_state_next = w_rd_word[2] ? S_BURST : S_STALL;
          w_count_next = w_rd_word[2] ? CNT_BW : CNT_BR;
        end else if (w_pc_inc == r_wp) begin
          w_state_next     = S_IDLE;
          w_done_pend_next = 1'b1;
        end
      end
      S_STALL, S_BURST: begin
        // Burst data past the end of the program is replaced by zeros.
        if ((r_state == S_BURST) && (r_pc < r_wp)) begin
          w_out_next = w_rd_word;
          w_pc_next  = w_pc_inc;
        end
        w_count_next = r_count - CNT_ONE;
        if (r_count == CNT_ONE) begin
          if (w_pc_next < r_wp) begin
            w_state_next = S_ISSUE;
          end else begin
            w_state_next     = S_IDLE;
            w_done_pend_next = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_wp         <= w_wp_rst;
      r_count      <= '0;
      r_out        <= RESET_WORD;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_done_pend  <= 1'b0;
      r_load_ready <= (w_wp_rst < DEPTH_L);
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_wp         <= w_wp_next;
      r_count      <= w_count_next;
      r_out        <= w_out_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= w_done_next;
      r_done_pend  <= w_done_pend_next;
      r_load_ready <= (w_state_next == S_IDLE) && (w_wp_next < DEPTH_L);
    end
  end

  // Program memory, not cleared by reset.
  always_ff @(posedge clock_in) begin
    if (w_we && !reset_in) r_mem[r_wp[ADDRESS_WIDTH-1:0]] <= load_data_in;
  end

  assign current_instruction_out = r_out;
  assign program_counter_out     = r_pc[ADDRESS_WIDTH-1:0];
  assign program_length_out      = r_wp;
  assign busy_out                = r_busy;
  assign done_out                = r_done;
  assign load_ready_out          = r_load_ready;

endmodule
